// File: rtl/spi_acc_pkg.sv
// rtl/spi_acc_pkg.sv - shared types and helpers for the SPI word accumulator
package spi_acc_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO
//  clk, rst_     : clock, asynchronous active-low reset
//  push, din     : write request and data (ignored when full unless popping in the same cycle)
//  pop           : read request (ignored when empty)
//  dout, valid   : head entry and its valid flag; dout reads 0 while empty
//  level, full   : occupancy and full flag
module sync_fifo
    import spi_acc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_,
    input  logic                        push,
    input  logic [WIDTH-1:0]            din,
    input  logic                        pop,
    output logic [WIDTH-1:0]            dout,
    output logic                        valid,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (level != '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && valid;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    // Gate the head so the output is deterministic while empty and after reset.
    assign dout    = valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/spi_word_fifo_acc.sv
// rtl/spi_word_fifo_acc.sv - packs CS-framed SPI bytes into words and buffers them in a FIFO
//  clk, rst_                   : clock, asynchronous active-low reset
//  i_rx_dv, i_rx_byte          : received byte strobe and data
//  i_cs_n                      : synchronised chip select, high = idle
//  o_word_valid, o_word        : FIFO head handshake, accepted with i_word_ready
//  o_level, o_irq              : FIFO occupancy and registered level interrupt
//  o_overflow, o_abort_cnt     : sticky drop flag and saturating aborted-frame count
//  i_clr_err                   : clears o_overflow and o_abort_cnt
module spi_word_fifo_acc
    import spi_acc_pkg::*;
#(
    parameter int BYTES     = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1,
    parameter int IRQ_LEVEL = 1,
    parameter int CNT_W     = 8
) (
    input  logic                        clk,
    input  logic                        rst_,
    input  logic                        i_rx_dv,
    input  byte_t                       i_rx_byte,
    input  logic                        i_cs_n,
    output logic                        o_word_valid,
    output logic [BYTE_W*BYTES-1:0]     o_word,
    input  logic                        i_word_ready,
    output logic [level_w(DEPTH)-1:0]   o_level,
    output logic                        o_irq,
    output logic                        o_overflow,
    output logic [CNT_W-1:0]            o_abort_cnt,
    input  logic                        i_clr_err
);

    localparam int W  = BYTE_W * BYTES;
    localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int LW = level_w(DEPTH);

    logic [IW-1:0] idx;
    logic [IW-1:0] idx_next;
    logic [W-1:0]  shreg;
    logic [W-1:0]  shreg_next;
    logic [W-1:0]  word_asm;
    logic          cs_q;
    logic          cs_rise;
    logic          accept;
    logic          last;
    logic          complete;
    logic          abort;
    logic          fifo_full;
    logic          pop_ok;
    logic          push_ok;
    logic          overflow_ev;
    logic [LW-1:0] level_next;

    assign cs_rise  = i_cs_n && !cs_q;
    // A byte in the same cycle as the CS rising edge still belongs to the closing frame.
    assign accept   = i_rx_dv && (!i_cs_n || cs_rise);
    assign last     = (idx == IW'(BYTES - 1));
    assign complete = accept && last;

    always_comb begin
        word_asm   = shreg;
        idx_next   = idx;
        abort      = 1'b0;
        for (int i = 0; i < BYTES; i++) begin
            if (accept && idx == IW'(i)) begin
                if (MSB_FIRST != 0) begin
                    word_asm[W-BYTE_W*(i+1) +: BYTE_W] = i_rx_byte;
                end else begin
                    word_asm[BYTE_W*i +: BYTE_W] = i_rx_byte;
                end
            end
        end
        shreg_next = word_asm;
        if (accept) begin
            idx_next = last ? '0 : idx + 1'b1;
        end
        if (complete) begin
            shreg_next = '0;
        end
        // Abort is judged after the same-cycle byte is counted, so a completing byte never aborts.
        if (cs_rise && idx_next != '0) begin
            abort      = 1'b1;
            idx_next   = '0;
            shreg_next = '0;
        end
    end

    sync_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (complete),
        .din   (word_asm),
        .pop   (i_word_ready),
        .dout  (o_word),
        .valid (o_word_valid),
        .level (o_level),
        .full  (fifo_full)
    );

    assign pop_ok      = i_word_ready && o_word_valid;
    assign push_ok     = complete && (!fifo_full || pop_ok);
    assign overflow_ev = complete && !push_ok;
    // Mirrors the FIFO's own level update so the interrupt lands in the same cycle as the level.
    assign level_next  = o_level + LW'(push_ok) - LW'(pop_ok);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cs_q        <= 1'b1;
            idx         <= '0;
            shreg       <= '0;
            o_irq       <= 1'b0;
            o_overflow  <= 1'b0;
            o_abort_cnt <= '0;
        end else begin
            cs_q  <= i_cs_n;
            idx   <= idx_next;
            shreg <= shreg_next;
            o_irq <= (level_next >= LW'(IRQ_LEVEL));

            if (overflow_ev) begin
                o_overflow <= 1'b1;
            end else if (i_clr_err) begin
                o_overflow <= 1'b0;
            end

            if (abort) begin
                if (i_clr_err) begin
                    o_abort_cnt <= CNT_W'(1);
                end else if (!(&o_abort_cnt)) begin
                    o_abort_cnt <= o_abort_cnt + 1'b1;
                end
            end else if (i_clr_err) begin
                o_abort_cnt <= '0;
            end
        end
    end

endmodule
